isa_io_initiator: RTL and testbench

ISA I/O-cycle initiator that turns a single-cycle request from the CPU core into a correctly timed ISA I/O read or write. It drives the address, AEN, IOR#/IOW# strobes and write data that the HGC and other I/O responders decode. It captures read data when a responder drives the bus and returns 8'hFF when no responder does. It sits between the CPU bus interface and the shared ISA-side signals feeding the video and peripheral blocks.

---
 rtl/isa_io_initiator_if.sv | 30 +++
 rtl/isa_io_initiator.sv | 152 +++++++++++++++
 tb/tb_isa_io_initiator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/isa_io_initiator_if.sv
// Signal bundle between the ISA I/O initiator, the CPU request side and the ISA-side responders.
// The master modport is the initiator's view; slave is the environment's.
interface isa_io_initiator_if;
    logic        req;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        busy;
    logic        ack;
    logic [7:0]  rdata;
    logic        err;
    logic [15:0] bus_a;
    logic        bus_aen;
    logic        bus_ior_l;
    logic        bus_iow_l;
    logic [7:0]  bus_d;
    logic [7:0]  bus_din;
    logic        bus_dir;
    logic        bus_rdy;

    modport master (
        input  req, req_wr, req_addr, req_wdata, bus_din, bus_dir, bus_rdy,
        output busy, ack, rdata, err, bus_a, bus_aen, bus_ior_l, bus_iow_l, bus_d
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata, bus_din, bus_dir, bus_rdy,
        input  busy, ack, rdata, err, bus_a, bus_aen, bus_ior_l, bus_iow_l, bus_d
    );
endinterface

// File: rtl/isa_io_initiator.sv
// ISA I/O-cycle initiator: turns a one-cycle CPU request into a timed IOR#/IOW# cycle
// with setup, IOCHRDY-extended strobe, hold, read capture and wait timeout.
module isa_io_initiator #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned MAX_WAIT   = 64
) (
    input  logic               clk,
    input  logic               reset,
    isa_io_initiator_if.master io
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] a_q, a_d;
    logic        aen_q, aen_d;
    logic        ior_l_q, ior_l_d;
    logic        iow_l_q, iow_l_d;
    logic [7:0]  d_q, d_d;
    logic        strobe_end;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        a_d        = a_q;
        aen_d      = aen_q;
        ior_l_d    = ior_l_q;
        iow_l_d    = iow_l_q;
        d_d        = d_q;
        strobe_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (io.req) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LAST;
                    wr_d    = io.req_wr;
                    a_d     = io.req_addr;
                    if (io.req_wr) d_d = io.req_wdata;
                    aen_d   = 1'b0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LAST;
                    wcnt_d  = 8'd0;
                    if (wr_q) iow_l_d = 1'b0;
                    else      ior_l_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                // Ready cycles consume strobe time; not-ready cycles only count toward the timeout.
                if (io.bus_rdy) begin
                    if (cnt_q == 4'd0) strobe_end = 1'b1;
                    else               cnt_d = cnt_q - 4'd1;
                end else if (wcnt_q == WAIT_LAST) begin
                    strobe_end = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
                if (strobe_end) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LAST;
                    ior_l_d = 1'b1;
                    iow_l_d = 1'b1;
                    // A timed-out read never trusts the bus; it floats high.
                    if (!wr_q) rdata_d = (io.bus_dir && !err_d) ? io.bus_din : 8'hFF;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    aen_d   = 1'b1;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wcnt_q  <= 8'd0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 8'd0;
            err_q   <= 1'b0;
            a_q     <= 16'd0;
            aen_q   <= 1'b1;
            ior_l_q <= 1'b1;
            iow_l_q <= 1'b1;
            d_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            a_q     <= a_d;
            aen_q   <= aen_d;
            ior_l_q <= ior_l_d;
            iow_l_q <= iow_l_d;
            d_q     <= d_d;
        end
    end

    assign io.busy      = busy_q;
    assign io.ack       = ack_q;
    assign io.rdata     = rdata_q;
    assign io.err       = err_q;
    assign io.bus_a     = a_q;
    assign io.bus_aen   = aen_q;
    assign io.bus_ior_l = ior_l_q;
    assign io.bus_iow_l = iow_l_q;
    assign io.bus_d     = d_q;

endmodule

// File: tb/tb_isa_io_initiator.sv
// Directed bench for isa_io_initiator: writes, reads, waits, timeout, mid-cycle reset, back-to-back.
module tb_isa_io_initiator;

    logic clk = 1'b0;
    logic reset;
    logic       resp_en;
    logic [7:0] resp_d;

    int n_chk = 0;
    int n_err = 0;

    // Per-transaction observations
    int          ack_cyc, strb_first, iow_cnt, ior_cnt, aen_bad, a_bad, busy_bad;
    logic [7:0]  got_rdata, got_d;
    logic        got_err, got_busy, got_aen;

    isa_io_initiator_if ifc ();

    isa_io_initiator #(
        .SETUP_CYC (2),
        .STROBE_CYC(4),
        .HOLD_CYC  (2),
        .MAX_WAIT  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (ifc.master)
    );

    always #5 clk = ~clk;

    // Responder drives the bus only while IOR# is low
    assign ifc.bus_dir = resp_en & ~ifc.bus_ior_l;
    assign ifc.bus_din = (resp_en & ~ifc.bus_ior_l) ? resp_d : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request and observes it cycle by cycle until ack (or a 60-cycle bound).
    // bus_rdy is 0 in absolute cycles rlo..rhi; responder data switches to d_late from swap_cyc.
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                           input int rlo, input int rhi, input logic ren,
                           input logic [7:0] d_early, input logic [7:0] d_late, input int swap_cyc);
        int cyc;
        @(negedge clk);
        ifc.req = 1'b1; ifc.req_wr = wr; ifc.req_addr = addr; ifc.req_wdata = wd;
        resp_en = ren;
        @(posedge clk); #1;
        ifc.req = 1'b0;
        cyc = 1; ack_cyc = 0; strb_first = 0; iow_cnt = 0; ior_cnt = 0;
        aen_bad = 0; a_bad = 0; busy_bad = 0;
        while (ack_cyc == 0 && cyc <= 60) begin
            ifc.bus_rdy = !(cyc >= rlo && cyc <= rhi);
            resp_d = (cyc >= swap_cyc) ? d_late : d_early;
            @(negedge clk);
            if (!ifc.bus_iow_l) begin if (strb_first == 0) strb_first = cyc; iow_cnt++; end
            if (!ifc.bus_ior_l) begin if (strb_first == 0) strb_first = cyc; ior_cnt++; end
            if (ifc.ack) begin
                ack_cyc = cyc; got_rdata = ifc.rdata; got_err = ifc.err;
                got_busy = ifc.busy; got_aen = ifc.bus_aen; got_d = ifc.bus_d;
            end else begin
                if (ifc.bus_aen !== 1'b0) aen_bad++;
                if (ifc.bus_a !== addr) a_bad++;
                if (ifc.busy !== 1'b1) busy_bad++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        ifc.bus_rdy = 1'b1;
        resp_en = 1'b0;
    endtask

    initial begin
        int acks;
        reset = 1'b1;
        resp_en = 1'b0; resp_d = 8'h00;
        ifc.req = 1'b0; ifc.req_wr = 1'b0; ifc.req_addr = 16'h0; ifc.req_wdata = 8'h0;
        ifc.bus_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aen",   ifc.bus_aen,   1);
        check("rst_ior",   ifc.bus_ior_l, 1);
        check("rst_iow",   ifc.bus_iow_l, 1);
        check("rst_a",     ifc.bus_a,     0);
        check("rst_d",     ifc.bus_d,     0);
        check("rst_busy",  ifc.busy,      0);
        check("rst_ack",   ifc.ack,       0);
        check("rst_rdata", ifc.rdata,     0);
        check("rst_err",   ifc.err,       0);
        reset = 1'b0;

        // Plain write, no waits
        run_txn(1'b1, 16'h03B8, 8'h0A, 0, -1, 1'b0, 8'h00, 8'h00, 0);
        check("wr_ack_cyc",   ack_cyc,    9);
        check("wr_strb_first", strb_first, 3);
        check("wr_iow_cnt",   iow_cnt,    4);
        check("wr_ior_cnt",   ior_cnt,    0);
        check("wr_aen_bad",   aen_bad,    0);
        check("wr_a_bad",     a_bad,      0);
        check("wr_busy_bad",  busy_bad,   0);
        check("wr_d",         got_d,      8'h0A);
        check("wr_err",       got_err,    0);
        check("wr_ack_busy",  got_busy,   0);
        check("wr_ack_aen",   got_aen,    1);

        // Read with responder present
        run_txn(1'b0, 16'h03BA, 8'h55, 0, -1, 1'b1, 8'h8F, 8'h8F, 0);
        check("rd_ack_cyc", ack_cyc,   9);
        check("rd_ior_cnt", ior_cnt,   4);
        check("rd_iow_cnt", iow_cnt,   0);
        check("rd_rdata",   got_rdata, 8'h8F);
        check("rd_err",     got_err,   0);
        check("rd_d_kept",  got_d,     8'h0A);

        // Read with nobody driving
        run_txn(1'b0, 16'h02F0, 8'h00, 0, -1, 1'b0, 8'h00, 8'h00, 0);
        check("nr_ack_cyc", ack_cyc,   9);
        check("nr_rdata",   got_rdata, 8'hFF);
        check("nr_err",     got_err,   0);

        // Three waits in strobe cycles 2..4; data changes in the last strobe cycle
        run_txn(1'b0, 16'h0300, 8'h00, 4, 6, 1'b1, 8'h11, 8'h5A, 9);
        check("wt_ack_cyc", ack_cyc,   12);
        check("wt_ior_cnt", ior_cnt,   7);
        check("wt_rdata",   got_rdata, 8'h5A);
        check("wt_err",     got_err,   0);

        // rdy stuck low after three counted strobe cycles: timeout
        run_txn(1'b0, 16'h0310, 8'h00, 6, 1000, 1'b1, 8'h77, 8'h77, 0);
        check("to_ack_cyc", ack_cyc,   16);
        check("to_ior_cnt", ior_cnt,   11);
        check("to_err",     got_err,   1);
        check("to_rdata",   got_rdata, 8'hFF);
        @(negedge clk);
        check("to_err_hold",   ifc.err,   1);
        check("to_rdata_hold", ifc.rdata, 8'hFF);

        // Err clears on the next transaction
        run_txn(1'b0, 16'h03BA, 8'h00, 0, -1, 1'b1, 8'h3C, 8'h3C, 0);
        check("ac_err",   got_err,   0);
        check("ac_rdata", got_rdata, 8'h3C);

        // Reset during cycle 4 of a write
        @(negedge clk);
        ifc.req = 1'b1; ifc.req_wr = 1'b1; ifc.req_addr = 16'h03B8; ifc.req_wdata = 8'hC3;
        @(posedge clk); #1;
        ifc.req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mr_iow_before", ifc.bus_iow_l, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mr_iow",  ifc.bus_iow_l, 1);
        check("mr_aen",  ifc.bus_aen,   1);
        check("mr_busy", ifc.busy,      0);
        check("mr_a",    ifc.bus_a,     0);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.ack) acks++;
        end
        check("mr_no_ack", acks, 0);
        run_txn(1'b1, 16'h03B8, 8'h0A, 0, -1, 1'b0, 8'h00, 8'h00, 0);
        check("mr_next_ack_cyc", ack_cyc,  9);
        check("mr_next_iow_cnt", iow_cnt,  4);

        // Back-to-back writes with req held high
        @(negedge clk);
        ifc.req = 1'b1; ifc.req_wr = 1'b1; ifc.req_addr = 16'h0300; ifc.req_wdata = 8'h11;
        @(posedge clk); #1;
        ifc.req_addr = 16'h0301; ifc.req_wdata = 8'h22;
        ack_cyc = 0; aen_bad = 0;
        for (int c = 1; c <= 30 && ack_cyc == 0; c++) begin
            @(negedge clk);
            if (ifc.ack) begin
                ack_cyc = c; got_aen = ifc.bus_aen; got_d = ifc.bus_d;
            end else begin
                if (ifc.bus_aen !== 1'b0 || ifc.bus_a !== 16'h0300) aen_bad++;
                @(posedge clk); #1;
            end
        end
        check("bb1_ack_cyc", ack_cyc, 9);
        check("bb1_bus_bad", aen_bad, 0);
        check("bb1_ack_aen", got_aen, 1);
        check("bb1_d",       got_d,   8'h11);
        @(posedge clk); #1;
        ifc.req = 1'b0;
        @(negedge clk);
        check("bb2_aen_low", ifc.bus_aen, 0);
        check("bb2_a",       ifc.bus_a,   16'h0301);
        check("bb2_busy",    ifc.busy,    1);
        check("bb2_ack_off", ifc.ack,     0);
        ack_cyc = 0;
        for (int c = 1; c <= 30 && ack_cyc == 0; c++) begin
            if (ifc.ack) begin
                ack_cyc = c; got_d = ifc.bus_d;
            end else begin
                @(negedge clk);
            end
        end
        check("bb2_ack_cyc", ack_cyc, 9);
        check("bb2_d",       got_d,   8'h22);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
